// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Memory access stage between execute and the register file write port.
// Accepts one load or store per start strobe, checks alignment, drives a
// req/ack data-memory handshake with byte enables and lane-replicated store
// data. For loads it hands the register file the raw load-type code, the
// destination index and right-justified read data (extension is done in the
// register file).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle request strobe (honoured only when idle)
//   ld_type, st_type          load/store op codes (register-file RFWr encoding)
//   addr, st_data, rd         byte address, store data, load destination
//   mem_req/mem_we/mem_addr   memory request, write flag, word address
//   mem_be/mem_wdata          byte enables and replicated write data
//   mem_rdata/mem_ack         read data and one-cycle completion from memory
//   rf_wr/rf_a3/rf_wd         register file write type, index and data
//   busy                      request in flight (CPU stall)
//   done/err                  one-cycle completion / error pulses
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  st_type,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [2:0]  rf_wr,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic [2:0]  ld_q;
    logic [1:0]  st_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [4:0]  rd_q;

    logic [7:0]  tmo_cnt;
    logic        err_q;
    logic        noop_q;

    logic        err_next;
    logic        noop_next;
    logic        accept;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        capture;

    // Word ops need a word-aligned address, halfword ops an even address.
    function automatic logic misaligned(input logic [2:0] ld, input logic [1:0] st,
                                        input logic [1:0] off);
        logic word;
        logic half;
        word = (ld == 3'b001) || (st == 2'b01);
        half = (ld == 3'b010) || (ld == 3'b100) || (st == 2'b10);
        return (word && (off != 2'b00)) || (half && off[0]);
    endfunction

    // Loads (st == 00) read the full word.
    function automatic logic [3:0] lane_be(input logic [1:0] st, input logic [1:0] off);
        case (st)
            2'b10:   return off[1] ? 4'b1100 : 4'b0011;
            2'b11:   return 4'b0001 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the narrow store value into every lane so the memory only
    // has to honour the byte enables.
    function automatic logic [31:0] lane_data(input logic [1:0] st, input logic [31:0] d);
        case (st)
            2'b01:   return d;
            2'b10:   return {2{d[15:0]}};
            2'b11:   return {4{d[7:0]}};
            default: return 32'h0000_0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        noop_next  = 1'b0;
        accept     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_be     = 4'b0000;
        mem_wdata  = 32'h0000_0000;
        busy       = 1'b0;
        done       = noop_q;
        err        = err_q;
        rf_wr      = 3'b000;
        rf_a3      = 5'd0;

        case (state)
            IDLE: begin
                if (start) begin
                    if ((ld_type == 3'b000) && (st_type == 2'b00)) begin
                        noop_next = 1'b1;
                    end else if (((ld_type != 3'b000) && (st_type != 2'b00)) ||
                                 (ld_type > 3'b101) ||
                                 misaligned(ld_type, st_type, addr[1:0])) begin
                        err_next = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = REQ;
                    end
                end
            end

            REQ: begin
                mem_req   = 1'b1;
                busy      = 1'b1;
                mem_we    = (st_q != 2'b00);
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = lane_be(st_q, addr_q[1:0]);
                mem_wdata = lane_data(st_q, data_q);
                // Ack is tested first so it wins on the terminal timeout cycle.
                if (mem_ack) begin
                    capture    = (ld_q != 3'b000);
                    state_next = RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            RESP: begin
                done = 1'b1;
                if (ld_q != 3'b000) begin
                    rf_a3 = rd_q;
                    // x0 is hardwired: the read happened but nothing is written.
                    if (rd_q != 5'd0) begin
                        rf_wr = ld_q;
                    end
                end
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= 1'b0;
            noop_q  <= 1'b0;
            tmo_cnt <= 8'd0;
            rf_wd   <= 32'h0000_0000;
        end else begin
            err_q  <= err_next;
            noop_q <= noop_next;
            if (cnt_clr) begin
                tmo_cnt <= 8'd0;
            end else if (cnt_inc) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (capture) begin
                rf_wd <= mem_rdata >> {addr_q[1:0], 3'b000};
            end
        end
    end

    // Request fields are only observed while in REQ/RESP, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ld_q   <= ld_type;
            st_q   <= st_type;
            addr_q <= addr;
            data_q <= st_data;
            rd_q   <= rd;
        end
    end

endmodule
